spi_slave_receiver: RTL and testbench
=====================================

// Module: spi_slave_receiver
// PURPOSE
//   SPI slave front end of the router (mode 0: CPOL=0, CPHA=0, MSB first). Oversamples
//   sclk/mosi/ssN in the system clock domain and deserialises mosi into size-bit words.
//   Each completed word is presented on dataOut with a one-cycle dataValid strobe.
//   dataValid drives the enable of the downstream capture register; dataOut drives its dataIn.
//   Shifts txData out on miso in the same frame.
// PARAMETERS
//   size         8   word width in bits (>=2)
//   SYNC_STAGES  2   synchroniser depth on sclk, mosi and ssN (>=2)
// PORTS
//   clock       in   1     system clock; all logic on posedge
//   reset       in   1     asynchronous, active-high reset
//   sclk        in   1     SPI serial clock (asynchronous to clock)
//   mosi        in   1     SPI master-out data
//   ssN         in   1     SPI slave select, active low
//   txData      in   size  word to return to master; sampled at word start
//   miso        out  1     SPI master-in data; 0 while ssN is high (no tristate)
//   dataOut     out  size  last completed received word; held until the next word completes
//   dataValid   out  1     one-cycle pulse: dataOut updated this cycle
//   busy        out  1     high while a frame is active (synchronised ssN low)
//   frameError  out  1     one-cycle pulse: frame ended on a partial word
// BEHAVIOUR
//   - Reset (any time, including mid-frame): all outputs 0. Shift register, bit count and
//     tx shifter cleared. State -> IDLE. Synchroniser flops load idle levels
//     (sclk=0, mosi=0, ssN=1).
//   - Input constraint: sclk frequency <= clock/4. Each sclk high and low phase >= 2 clock cycles.
//   - Edge detect on synchronised sclk: rise = s & ~s_d, fall = ~s & s_d.
//   - FSM IDLE -> ACTIVE on synchronised ssN low: bitCount<=0, txShift<=txData, miso<=txData[size-1].
//     ACTIVE -> IDLE on synchronised ssN high.
//   - In ACTIVE on rise: rxShift <= {rxShift[size-2:0], mosi_s}, bitCount++.
//     When bitCount==size-1, the same clock edge loads dataOut with the completed word,
//     bitCount wraps to 0, and dataValid=1 in the following cycle only.
//     Latency: sclk pin rise -> dataValid = SYNC_STAGES+1 clocks.
//   - In ACTIVE on fall: if bitCount==0 (word boundary), load txShift<=txData and drive
//     miso<=txData[size-1]. Otherwise shift left and drive miso<=next bit.
//     The first word's MSB is already driven from the IDLE->ACTIVE transition.
//   - Multi-word frames: words are received back to back with no gap. Each one pulses dataValid.
//   - Frame end (ssN rise synchronised):
//     - bitCount!=0: frameError=1 for one cycle, partial word discarded, dataOut unchanged.
//     - bitCount==0: no error.
//     miso<=0, busy<=0.
//   - Simultaneous sclk rise and ssN deassert in one cycle: the rise is processed first.
//     The frame-end check then uses the updated bitCount, so the final bit is never lost.
//   - sclk edges while IDLE are ignored. dataOut holds its value across frames.
//   - busy equals (state==ACTIVE), registered.
// STRUCTURE
//   - Shared package router_spi_pkg: SPI_WORD_SIZE=8, state typedef {IDLE, ACTIVE},
//     SPI_IDLE_SCLK=0, SPI_IDLE_SS=1.
//   - One sub-module: sync_ff #(.STAGES, .RESET_VAL). Three instances: sclk, mosi, ssN.
//   - The rest is flat: edge detect, FSM, rx shifter, tx shifter, bit counter.
// TESTING
//   - Reset: assert reset mid-frame after 5 bits -> all outputs 0 immediately. After release,
//     a new frame sending 0xA5 -> dataOut=0xA5, exactly one dataValid pulse.
//   - Single word: ssN low, send 0x3C at clock/8, txData=0xC3 -> dataOut=0x3C, dataValid
//     SYNC_STAGES+1 clocks after the 8th sclk rise. Master samples miso = 0xC3.
//   - Back-to-back: one frame sending 0x01,0x80,0xFF with txData changed to 0x55 and then
//     0xAA between words -> three dataValid pulses with dataOut 0x01,0x80,0xFF.
//     miso returns 0x55,0xAA,0xAA.
//   - Partial word: ssN rises after 3 bits of 0xE0 -> frameError pulses once, no dataValid,
//     dataOut keeps its previous value.
//   - Boundary: the 8th sclk rise and ssN deassert arrive in the same clock -> dataValid=1,
//     frameError=0.
//   - Idle noise: sclk toggling with ssN high -> busy=0, no dataValid, miso=0 throughout.

Source files
------------

// File: rtl/router_spi_pkg.sv
// Shared constants and types for the router SPI slave front end.
package router_spi_pkg;

    localparam int unsigned SPI_WORD_SIZE = 8;

    // Idle pin levels loaded into the synchronisers on reset.
    localparam logic SPI_IDLE_SCLK = 1'b0;
    localparam logic SPI_IDLE_MOSI = 1'b0;
    localparam logic SPI_IDLE_SS   = 1'b1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage further along the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain registers; reset to the pin's idle level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: oversamples the SPI pins, deserialises mosi into words
// and serialises txData onto miso within the same frame.
module spi_slave_receiver
    import router_spi_pkg::*;
#(
    parameter int unsigned size        = SPI_WORD_SIZE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sclk,
    input  logic            mosi,
    input  logic            ssN,
    input  logic [size-1:0] txData,
    output logic            miso,
    output logic [size-1:0] dataOut,
    output logic            dataValid,
    output logic            busy,
    output logic            frameError
);

    localparam int unsigned CntW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(size - 1);

    logic sclk_s;
    logic mosi_s;
    logic ss_n_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_IDLE_SCLK)) u_sync_sclk (
        .clock (clock),
        .reset (reset),
        .d     (sclk),
        .q     (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_IDLE_MOSI)) u_sync_mosi (
        .clock (clock),
        .reset (reset),
        .d     (mosi),
        .q     (mosi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_IDLE_SS)) u_sync_ss_n (
        .clock (clock),
        .reset (reset),
        .d     (ssN),
        .q     (ss_n_s)
    );

    spi_state_e      state_q, state_d;
    logic            sclk_prev_q, sclk_prev_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [size-1:0] rx_shift_q, rx_shift_d;
    logic [size-1:0] tx_shift_q, tx_shift_d;
    logic            miso_q, miso_d;
    logic [size-1:0] data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_error_q, frame_error_d;

    logic sclk_rise;
    logic sclk_fall;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Frame FSM plus rx/tx shifters; a rise is applied before the frame-end check
    // so a final bit coinciding with ssN deassert still completes its word.
    always_comb begin
        state_d       = state_q;
        sclk_prev_d   = sclk_s;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!ss_n_s) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    tx_shift_d = txData;
                    miso_d     = txData[size-1];
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[size-2:0], mosi_s};
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d    = '0;
                        data_out_d   = {rx_shift_q[size-2:0], mosi_s};
                        data_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = txData;
                        miso_d     = txData[size-1];
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[size-2];
                    end
                end

                if (ss_n_s) begin
                    state_d       = IDLE;
                    miso_d        = 1'b0;
                    frame_error_d = (bit_cnt_d != '0);
                    bit_cnt_d     = '0;
                    rx_shift_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sclk_prev_q   <= SPI_IDLE_SCLK;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            miso_q        <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign miso       = miso_q;
    assign dataOut    = data_out_q;
    assign dataValid  = data_valid_q;
    assign busy       = (state_q == ACTIVE);
    assign frameError = frame_error_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver: an SPI master model drives frames,
// and expected words, miso data and error pulses come from per-frame bookkeeping.
module tb_spi_slave_receiver;

    localparam int SIZE = 8;
    localparam int SYNC = 2;
    localparam int HALF = 4;  // sclk half period in system clocks (clock/8)

    logic            clock = 1'b0;
    logic            reset;
    logic            sclk;
    logic            mosi;
    logic            ssN;
    logic [SIZE-1:0] txData;
    logic            miso;
    logic [SIZE-1:0] dataOut;
    logic            dataValid;
    logic            busy;
    logic            frameError;

    spi_slave_receiver #(.size(SIZE), .SYNC_STAGES(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .ssN        (ssN),
        .txData     (txData),
        .miso       (miso),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .busy       (busy),
        .frameError (frameError)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed pulses, recorded away from the active edge.
    logic [7:0] dv_q[$];
    int         dv_cyc[$];
    int         fe_cnt = 0;

    // Model of the last completed word.
    logic [7:0] exp_data_out = 8'h00;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (dataValid) begin
                dv_q.push_back(dataOut);
                dv_cyc.push_back(cyc);
            end
            if (frameError) fe_cnt = fe_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_obs();
        dv_q.delete();
        dv_cyc.delete();
        fe_cnt = 0;
    endtask

    task automatic frame_begin(input logic [7:0] first_tx);
        txData = first_tx;
        ssN    = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        ssN = 1'b1;
        tick(8);
    endtask

    // Master side: drive nbits of w MSB first, sample miso on each rising sclk.
    task automatic send_word(input logic [7:0] w, input int nbits, input logic [7:0] next_tx,
                             input bit end_on_last_rise, output logic [7:0] got,
                             output int last_rise_cyc);
        got = 8'h00;
        last_rise_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            tick(HALF);
            got[7-i] = miso;
            sclk = 1'b1;
            if (i == nbits - 1 && end_on_last_rise) ssN = 1'b1;
            last_rise_cyc = cyc;
            if (i == 0) txData = next_tx;
            tick(HALF);
            if (!(i == nbits - 1 && end_on_last_rise)) sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        int         lr;
        tick(3);
        n_checks++;
        if ({miso, dataOut, dataValid, busy, frameError} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 000",
                     {miso, dataOut, dataValid, busy, frameError});
        end
        reset = 1'b0;
        tick(4);

        // Put a known word in dataOut so the mid-frame reset visibly clears it.
        frame_begin(8'h00);
        send_word(8'h5A, 8, 8'h00, 1'b0, got, lr);
        frame_end();
        exp_data_out = 8'h5A;
        n_checks++;
        if (dataOut !== exp_data_out) begin
            n_fail++;
            $display("FAIL reset_preload: dataOut got %h expected %h", dataOut, exp_data_out);
        end

        frame_begin(8'hFF);
        send_word(8'h3C, 5, 8'hFF, 1'b0, got, lr);
        n_checks++;
        if (busy !== 1'b1 || miso !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe_pre: busy/miso got %b%b expected 11", busy, miso);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({miso, dataOut, dataValid, busy, frameError} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_midframe: got %h expected 000",
                     {miso, dataOut, dataValid, busy, frameError});
        end
        exp_data_out = 8'h00;
        ssN  = 1'b1;
        sclk = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(4);

        clear_obs();
        frame_begin(8'h00);
        send_word(8'hA5, 8, 8'h00, 1'b0, got, lr);
        frame_end();
        exp_data_out = 8'hA5;
        n_checks++;
        if (dv_q.size() != 1 || dataOut !== exp_data_out || fe_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_recover: pulses %0d dataOut %h errors %0d expected 1 %h 0",
                     dv_q.size(), dataOut, fe_cnt, exp_data_out);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] got;
        int         lr;
        clear_obs();
        frame_begin(8'hC3);
        send_word(8'h3C, 8, 8'hC3, 1'b0, got, lr);
        frame_end();
        exp_data_out = 8'h3C;
        n_checks++;
        if (dv_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_pulses: got %0d expected 1", dv_q.size());
        end else begin
            n_checks++;
            if (dv_q[0] !== 8'h3C) begin
                n_fail++;
                $display("FAIL single_data: got %h expected 3c", dv_q[0]);
            end
            n_checks++;
            if (dv_cyc[0] - lr != SYNC + 1) begin
                n_fail++;
                $display("FAIL single_latency: got %0d expected %0d", dv_cyc[0] - lr, SYNC + 1);
            end
        end
        n_checks++;
        if (got !== 8'hC3) begin
            n_fail++;
            $display("FAIL single_miso: got %h expected c3", got);
        end
        n_checks++;
        if (fe_cnt != 0 || busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: errors/busy/miso got %0d %b %b expected 0 0 0",
                     fe_cnt, busy, miso);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        logic [7:0] txs[4];
        logic [7:0] got;
        int         lr;
        words = '{8'h01, 8'h80, 8'hFF};
        txs   = '{8'h55, 8'hAA, 8'hAA, 8'hAA};
        clear_obs();
        frame_begin(txs[0]);
        for (int k = 0; k < 3; k++) begin
            send_word(words[k], 8, txs[k+1], 1'b0, got, lr);
            n_checks++;
            if (got !== txs[k]) begin
                n_fail++;
                $display("FAIL b2b_miso[%0d]: got %h expected %h", k, got, txs[k]);
            end
        end
        frame_end();
        exp_data_out = 8'hFF;
        n_checks++;
        if (dv_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 3", dv_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (dv_q[k] !== words[k]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", k, dv_q[k], words[k]);
                end
            end
        end
        n_checks++;
        if (fe_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_error: got %0d expected 0", fe_cnt);
        end
    endtask

    task automatic test_partial();
        logic [7:0] got;
        int         lr;
        clear_obs();
        frame_begin(8'h0F);
        send_word(8'hE0, 3, 8'h0F, 1'b0, got, lr);
        frame_end();
        n_checks++;
        if (fe_cnt != 1 || dv_q.size() != 0 || dataOut !== exp_data_out) begin
            n_fail++;
            $display("FAIL partial: errors %0d pulses %0d dataOut %h expected 1 0 %h",
                     fe_cnt, dv_q.size(), dataOut, exp_data_out);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] got;
        int         lr;
        clear_obs();
        frame_begin(8'h00);
        send_word(8'h96, 8, 8'h00, 1'b1, got, lr);
        tick(8);
        sclk = 1'b0;
        tick(4);
        exp_data_out = 8'h96;
        n_checks++;
        if (dv_q.size() != 1 || dataOut !== exp_data_out || fe_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary: pulses %0d dataOut %h errors %0d busy %b expected 1 %h 0 0",
                     dv_q.size(), dataOut, fe_cnt, busy, exp_data_out);
        end
    endtask

    task automatic test_idle_noise();
        clear_obs();
        ssN = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            n_checks++;
            if (busy !== 1'b0 || miso !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_noise[%0d]: busy/miso got %b%b expected 00", i, busy, miso);
            end
            if ($urandom_range(0, 2) == 0) sclk = ~sclk;
            mosi = 1'($urandom);
        end
        sclk = 1'b0;
        tick(6);
        n_checks++;
        if (dv_q.size() != 0 || fe_cnt != 0 || dataOut !== exp_data_out) begin
            n_fail++;
            $display("FAIL idle_quiet: pulses %0d errors %0d dataOut %h expected 0 0 %h",
                     dv_q.size(), fe_cnt, dataOut, exp_data_out);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] words[4];
        logic [7:0] txs[5];
        logic [7:0] got;
        logic [7:0] mask;
        int         lr;
        int         nw;
        int         tail;
        for (int f = 0; f < 12; f++) begin
            nw   = $urandom_range(0, 3);
            tail = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            if (nw == 0 && tail == 0) tail = $urandom_range(1, 7);
            for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
            for (int k = 0; k < 5; k++) txs[k] = 8'($urandom);
            clear_obs();
            frame_begin(txs[0]);
            for (int k = 0; k < nw; k++) begin
                send_word(words[k], 8, txs[k+1], 1'b0, got, lr);
                n_checks++;
                if (got !== txs[k]) begin
                    n_fail++;
                    $display("FAIL rand_miso[%0d.%0d]: got %h expected %h", f, k, got, txs[k]);
                end
            end
            if (tail != 0) begin
                send_word(words[nw], tail, txs[nw+1], 1'b0, got, lr);
                mask = 8'hFF << (8 - tail);
                n_checks++;
                if ((got & mask) !== (txs[nw] & mask)) begin
                    n_fail++;
                    $display("FAIL rand_miso_tail[%0d]: got %h expected %h",
                             f, got & mask, txs[nw] & mask);
                end
            end
            frame_end();
            if (nw > 0) exp_data_out = words[nw-1];
            n_checks++;
            if (dv_q.size() != nw || fe_cnt != ((tail != 0) ? 1 : 0)
                || dataOut !== exp_data_out) begin
                n_fail++;
                $display("FAIL rand_frame[%0d]: pulses %0d errors %0d dataOut %h expected %0d %0d %h",
                         f, dv_q.size(), fe_cnt, dataOut, nw, (tail != 0) ? 1 : 0, exp_data_out);
            end else begin
                for (int k = 0; k < nw; k++) begin
                    n_checks++;
                    if (dv_q[k] !== words[k]) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d.%0d]: got %h expected %h",
                                 f, k, dv_q[k], words[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        ssN    = 1'b1;
        txData = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial();
        test_boundary();
        test_idle_noise();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
